clock_time_controller: RTL and testbench
========================================

// Module: clock_time_controller
// PURPOSE
//   Timekeeping and time-set sequencer for the digital clock. Holds hours/minutes/seconds in 24h form and advances
//   them on a 1 Hz enable. Runs a button-driven set-mode FSM to adjust hours and minutes.
//   Owns the 12h/24h display-format flag. Its hours output feeds the 24h->12h converter; display logic uses fmt12
//   to pick converted or raw hours.
// PARAMETERS
//   RESET_HOUR  0  hours value loaded on reset (0..23)
//   RESET_MIN   0  minutes value loaded on reset (0..59)
// PORTS
//   clk       in   1  system clock, all state updates on rising edge
//   reset     in   1  synchronous, active-high reset
//   tick      in   1  one-cycle 1 Hz enable pulse
//   btn_mode  in   1  one-cycle pulse (pre-debounced): advance set-mode state
//   btn_inc   in   1  one-cycle pulse (pre-debounced): increment field being edited
//   btn_fmt   in   1  one-cycle pulse (pre-debounced): toggle 12h/24h format
//   hours     out  7  current hours 0..23
//   minutes   out  7  current minutes 0..59
//   seconds   out  7  current seconds 0..59
//   fmt12     out  1  1 = display in 12h format, 0 = 24h
//   edit_sel  out  2  0 = running, 1 = editing hours, 2 = editing minutes
//   blink     out  1  blink phase for the field being edited
//   day_roll  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 transition
// BEHAVIOUR
//   - All outputs are registered. Every event is visible on the outputs one clk after the cycle in which it is sampled.
//   - Reset values: hours=RESET_HOUR, minutes=RESET_MIN, seconds=0, state=RUN, fmt12=0, edit_sel=0, blink=0,
//     day_roll=0.
//   - Reset applies in any state, including mid-edit, and takes priority over every other input.
//   - FSM states are RUN, SET_HR and SET_MIN; edit_sel encodes the state.
//   - State transitions on btn_mode: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN.
//   - On the SET_MIN->RUN transition, seconds are cleared to 0.
//   - RUN behaviour:
//       - On tick, seconds increments. 59 wraps to 0 with a carry into minutes.
//       - Minutes 59 wraps to 0 with a carry into hours.
//       - Hours 23 wraps to 0 and pulses day_roll for exactly one cycle.
//       - btn_inc is ignored.
//   - SET_HR behaviour:
//       - The clock is frozen: tick does not advance time.
//       - btn_inc: hours = (hours==23) ? 0 : hours+1. Minutes and seconds are untouched, and day_roll is not pulsed.
//   - SET_MIN behaviour:
//       - The clock is frozen.
//       - btn_inc: minutes = (minutes==59) ? 0 : minutes+1. No carry into hours.
//   - blink:
//       - Toggles on each tick while in SET_HR or SET_MIN.
//       - Forced to 0 in RUN.
//       - Forced to 1 on entry to each set state, so the field is immediately visible.
//   - btn_fmt toggles fmt12 in any state. It is independent of the FSM and of time values.
//   - Simultaneous inputs:
//       - btn_mode together with btn_inc: mode wins and inc is dropped.
//       - tick together with btn_mode in RUN: the tick is applied and the state moves to SET_HR in the same cycle.
//       - tick together with btn_mode in SET_MIN: the tick is ignored, the state returns to RUN, and seconds=0.
//   - Width rules:
//       - Time fields are 7 bits, matching the converter input width.
//       - Values outside 0..23 / 0..59 are unreachable. On reaching such a value, the next increment wraps the field
//         to 0.
// TESTING
//   1. Reset, then 3 tick pulses -> seconds=3, minutes=0, hours=0, edit_sel=0.
//   2. Set to 23:59 and exit:
//        - btn_mode; 23 btn_inc; btn_mode; 59 btn_inc; btn_mode -> 23:59:00, edit_sel=0.
//        - Then 60 ticks -> 00:00:00 with exactly one day_roll pulse.
//   3. In SET_HR, apply 5 ticks -> hours/minutes/seconds unchanged; blink toggles each tick starting from 1.
//   4. In SET_HR at hours=7, btn_mode and btn_inc in the same cycle -> edit_sel=2, hours=7.
//   5. In SET_MIN at minutes=59 with hours=4, btn_inc -> minutes=0, hours=4.
//   6. btn_fmt then reset -> fmt12=1, then 0.
//      Reset asserted mid-SET_MIN -> next cycle state RUN, 00:00:00, blink=0.

Source files
------------

// File: rtl/clock_time_controller.sv
// Timekeeping plus button-driven hour/minute set sequencer for the digital clock.
// Time is kept in 24h form; fmt12 only tells the display which hours form to show.
//
// state   | meaning
// --------+-------------------------------------------
// RUN     | clock advances on tick, btn_inc ignored
// SET_HR  | clock frozen, btn_inc steps hours
// SET_MIN | clock frozen, btn_inc steps minutes
module clock_time_controller #(
  parameter int RESET_HOUR = 0,
  parameter int RESET_MIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_fmt,
  output logic [6:0] hours,
  output logic [6:0] minutes,
  output logic [6:0] seconds,
  output logic       fmt12,
  output logic [1:0] edit_sel,
  output logic       blink,
  output logic       day_roll
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      hours    <= 7'(RESET_HOUR);
      minutes  <= 7'(RESET_MIN);
      seconds  <= 7'd0;
      fmt12    <= 1'b0;
      edit_sel <= 2'd0;
      blink    <= 1'b0;
      day_roll <= 1'b0;
    end else begin
      day_roll <= 1'b0;
      if (btn_fmt) fmt12 <= ~fmt12;

      case (state)
        RUN: begin
          blink <= 1'b0;
          // >= comparisons make any out-of-range value wrap to 0 on its next step
          if (tick) begin
            if (seconds >= 7'd59) begin
              seconds <= 7'd0;
              if (minutes >= 7'd59) begin
                minutes <= 7'd0;
                if (hours >= 7'd23) begin
                  hours    <= 7'd0;
                  day_roll <= 1'b1;
                end else begin
                  hours <= hours + 7'd1;
                end
              end else begin
                minutes <= minutes + 7'd1;
              end
            end else begin
              seconds <= seconds + 7'd1;
            end
          end
          if (btn_mode) begin
            state    <= SET_HR;
            edit_sel <= 2'd1;
            blink    <= 1'b1;
          end
        end

        SET_HR: begin
          if (btn_mode) begin
            state    <= SET_MIN;
            edit_sel <= 2'd2;
            blink    <= 1'b1;
          end else begin
            if (btn_inc) hours <= (hours >= 7'd23) ? 7'd0 : hours + 7'd1;
            if (tick) blink <= ~blink;
          end
        end

        SET_MIN: begin
          if (btn_mode) begin
            state    <= RUN;
            edit_sel <= 2'd0;
            blink    <= 1'b0;
            seconds  <= 7'd0;
          end else begin
            if (btn_inc) minutes <= (minutes >= 7'd59) ? 7'd0 : minutes + 7'd1;
            if (tick) blink <= ~blink;
          end
        end

        default: begin
          state    <= RUN;
          edit_sel <= 2'd0;
          blink    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_controller.sv
// Bench for clock_time_controller: directed scenarios plus random button/tick traffic,
// checked against a seconds-of-day reference model.
module tb_clock_time_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       btn_fmt = 1'b0;
  logic [6:0] hours, minutes, seconds;
  logic       fmt12;
  logic [1:0] edit_sel;
  logic       blink;
  logic       day_roll;

  int total = 0;
  int bad   = 0;

  // reference model: time as seconds since midnight, mode 0=run 1=hours 2=minutes
  int m_t     = 0;
  int m_mode  = 0;
  int m_blink = 0;
  int m_f12   = 0;
  int m_roll  = 0;
  int roll_cnt = 0;

  clock_time_controller #(.RESET_HOUR(0), .RESET_MIN(0)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .btn_fmt(btn_fmt), .hours(hours), .minutes(minutes), .seconds(seconds),
    .fmt12(fmt12), .edit_sel(edit_sel), .blink(blink), .day_roll(day_roll)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    cmp("hours",    int'(hours),    m_t / 3600);
    cmp("minutes",  int'(minutes),  (m_t / 60) % 60);
    cmp("seconds",  int'(seconds),  m_t % 60);
    cmp("fmt12",    int'(fmt12),    m_f12);
    cmp("edit_sel", int'(edit_sel), m_mode);
    cmp("blink",    int'(blink),    m_blink);
    cmp("day_roll", int'(day_roll), m_roll);
  endtask

  task automatic model_step(input bit rs, input bit tk, input bit md, input bit in, input bit fm);
    int h, mi;
    m_roll = 0;
    if (rs) begin
      m_t = 0; m_mode = 0; m_blink = 0; m_f12 = 0;
      return;
    end
    if (fm) m_f12 ^= 1;
    h  = m_t / 3600;
    mi = (m_t / 60) % 60;
    case (m_mode)
      0: begin
        if (tk) begin
          m_t = (m_t + 1) % 86400;
          if (m_t == 0) m_roll = 1;
        end
        m_blink = md ? 1 : 0;
        if (md) m_mode = 1;
      end
      1: begin
        if (md) begin
          m_mode = 2; m_blink = 1;
        end else begin
          if (in) m_t = ((h + 1) % 24) * 3600 + (m_t % 3600);
          if (tk) m_blink ^= 1;
        end
      end
      default: begin
        if (md) begin
          m_mode = 0; m_blink = 0; m_t = m_t - (m_t % 60);
        end else begin
          if (in) m_t = h * 3600 + ((mi + 1) % 60) * 60 + (m_t % 60);
          if (tk) m_blink ^= 1;
        end
      end
    endcase
  endtask

  // drive one cycle of inputs, update the model, then check all outputs after the edge
  task automatic cyc(input bit rs, input bit tk, input bit md, input bit in, input bit fm);
    reset = rs; tick = tk; btn_mode = md; btn_inc = in; btn_fmt = fm;
    @(posedge clk);
    model_step(rs, tk, md, in, fm);
    #1;
    reset = 1'b0; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_fmt = 1'b0;
    if (day_roll === 1'b1) roll_cnt++;
    check_all();
  endtask

  initial begin
    @(posedge clk); #1;

    // 1: reset then three ticks
    cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    cmp("t1_seconds", int'(seconds), 3);
    cmp("t1_edit_sel", int'(edit_sel), 0);

    // 2: set 23:59, exit, then roll over midnight
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (23) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (59) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cmp("t2_hours", int'(hours), 23);
    cmp("t2_minutes", int'(minutes), 59);
    cmp("t2_seconds", int'(seconds), 0);
    roll_cnt = 0;
    repeat (60) cyc(0, 1, 0, 0, 0);
    cmp("t2_midnight_h", int'(hours), 0);
    cmp("t2_midnight_m", int'(minutes), 0);
    cmp("t2_roll_count", roll_cnt, 1);

    // 3: ticks while editing hours freeze time and toggle blink
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cmp("t3_blink_entry", int'(blink), 1);
    repeat (5) cyc(0, 1, 0, 0, 0);
    cmp("t3_blink_after5", int'(blink), 0);
    cmp("t3_seconds", int'(seconds), 0);

    // 4: mode and inc together in SET_HR at hours=7
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    cmp("t4_edit_sel", int'(edit_sel), 2);
    cmp("t4_hours", int'(hours), 7);

    // 5: minute wrap in SET_MIN without carry
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (4) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (59) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cmp("t5_minutes", int'(minutes), 0);
    cmp("t5_hours", int'(hours), 4);

    // 6: format toggle, reset clears it; reset mid-SET_MIN
    cyc(0, 0, 0, 0, 1);
    cmp("t6_fmt_set", int'(fmt12), 1);
    cyc(1, 0, 0, 0, 0);
    cmp("t6_fmt_clr", int'(fmt12), 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 0);
    cmp("t6_state", int'(edit_sel), 0);
    cmp("t6_hours", int'(hours), 0);
    cmp("t6_blink", int'(blink), 0);

    // simultaneous tick + mode in RUN and in SET_MIN
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cmp("tm_run_sec", int'(seconds), 2);
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    cmp("tm_setmin_sec", int'(seconds), 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0,
          $urandom_range(0, 1) == 1,
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 11) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
